// File: rtl/uart_debug_pkg.sv
// Shared types and constants for the debug UART receiver slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: rx_state_t FSM encoding, data width, default bit timing and FIFO depth,
// and an even-parity helper used when the parity build option is enabled.
package uart_debug_pkg;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_DEFAULT_CLKS_PER_BIT = 868;   // 100 MHz / 115200 baud
    localparam int UART_DEFAULT_FIFO_DEPTH   = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    // Even parity: the parity bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_debug_rx_if.sv
// Byte-stream output bundle of the debug UART receiver (valid/ready plus status).
// Latency: n/a (wiring only).
// Backpressure: ready_i pops the FIFO head; it never stalls the serial line.
// master modport: receiver side (drives data/valid/count/errors, samples ready_i).
// slave  modport: consumer side.
interface uart_debug_rx_if #(
    parameter int FIFO_DEPTH = 16
) ();
    import uart_debug_pkg::*;

    logic [UART_DATA_BITS-1:0]   data_o;
    logic                        valid_o;
    logic                        ready_i;
    logic [$clog2(FIFO_DEPTH):0] count_o;
    logic                        frame_err_o;
    logic                        parity_err_o;
    logic                        overflow_o;

    modport master (
        output data_o, valid_o, count_o, frame_err_o, parity_err_o, overflow_o,
        input  ready_i
    );

    modport slave (
        input  data_o, valid_o, count_o, frame_err_o, parity_err_o, overflow_o,
        output ready_i
    );

endinterface

// File: rtl/uart_debug_fifo.sv
// Synchronous first-word-fall-through FIFO; head entry is visible on pop_dat while !empty.
// Latency: a push is visible on pop_dat/empty the cycle after the push edge.
// Backpressure: push while full (without a same-cycle pop) is dropped and flagged on drop.
// Ports: clk, reset (async, active-high); push/push_dat in; pop in; pop_dat, full, empty,
// count (0..DEPTH), drop (1-cycle, combinational) out. DEPTH must be a power of two >= 2.
module uart_debug_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_do_pop;
    logic w_do_push;

    assign empty    = (r_count == '0);
    assign full     = (r_count == (AW+1)'(DEPTH));
    assign w_do_pop = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign w_do_push = push && (!full || w_do_pop);
    assign drop      = push && !w_do_push;
    assign pop_dat   = r_mem[r_rd_ptr];
    assign count     = r_count;

    // Storage is reset so the head byte reads 0 out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_debug_rx.sv
// UART receiver for the core's debug TX line: 8N1 (8E1 with UART_DEBUG_RX_PARITY_EN), bytes into a FWFT FIFO.
// Latency: byte is on data_o/valid_o the cycle after the edge that samples the stop bit.
// Backpressure: none toward the line; a byte arriving at a full FIFO is dropped and overflow_o sticks.
// Ports: clk, reset (async, active-high), rxd (async serial in, idle high), bus (uart_debug_rx_if.master:
// data_o, valid_o, ready_i, count_o, frame_err_o, parity_err_o, overflow_o).
// Build option: define UART_DEBUG_RX_PARITY_EN for an even-parity bit between data and stop.
module uart_debug_rx
    import uart_debug_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,   // >= 4
    parameter int FIFO_DEPTH   = UART_DEFAULT_FIFO_DEPTH      // power of two, >= 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rxd,
    uart_debug_rx_if.master  bus
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

    // Two-flop synchroniser; idles high like the line so reset is not seen as a start bit.
    logic r_sync1;
    logic r_sync2;
    logic w_rx_s;

    rx_state_t                 r_state,   w_state_nxt;
    logic [CW-1:0]             r_cnt,     w_cnt_nxt;
    logic [2:0]                r_bit_idx, w_bit_idx_nxt;
    logic [UART_DATA_BITS-1:0] r_shift,   w_shift_nxt;

    logic w_push;
    logic w_frame_err;
    logic r_frame_err;
    logic r_overflow;

    logic w_fifo_full;
    logic w_fifo_empty;
    logic w_fifo_drop;

`ifdef UART_DEBUG_RX_PARITY_EN
    logic r_par_err,   w_par_err_nxt;
    logic w_parity_err;
    logic r_parity_err;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

    // FSM state and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
`ifdef UART_DEBUG_RX_PARITY_EN
            r_par_err    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_frame_err <= w_frame_err;
`ifdef UART_DEBUG_RX_PARITY_EN
            r_par_err    <= w_par_err_nxt;
            r_parity_err <= w_parity_err;
`endif
        end
    end

    // Next-state / datapath logic. Every sampling point is a counter terminal value, so
    // the counter restarts at 0 on each transition into a bit-timed state.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_push        = 1'b0;
        w_frame_err   = 1'b0;
`ifdef UART_DEBUG_RX_PARITY_EN
        w_par_err_nxt = r_par_err;
        w_parity_err  = 1'b0;
`endif

        case (r_state)
            IDLE: begin
                if (!w_rx_s) begin
                    w_state_nxt = START;
                    w_cnt_nxt   = '0;
                end
            end

            // Re-check the start bit at its midpoint to reject short glitches.
            START: begin
                if (r_cnt == CNT_HALF_END) begin
                    w_cnt_nxt = '0;
                    if (w_rx_s) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt   = DATA;
                        w_bit_idx_nxt = '0;
`ifdef UART_DEBUG_RX_PARITY_EN
                        w_par_err_nxt = 1'b0;
`endif
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            // Half a bit already elapsed in START, so full-bit counts land mid-bit.
            DATA: begin
                if (r_cnt == CNT_BIT_END) begin
                    w_cnt_nxt     = '0;
                    w_shift_nxt   = {w_rx_s, r_shift[UART_DATA_BITS-1:1]};
                    w_bit_idx_nxt = r_bit_idx + 1'b1;
                    if (r_bit_idx == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_DEBUG_RX_PARITY_EN
                        w_state_nxt = PARITY;
`else
                        w_state_nxt = STOP;
`endif
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

`ifdef UART_DEBUG_RX_PARITY_EN
            // Mismatch is only held here; it is reported together with the stop decision.
            PARITY: begin
                if (r_cnt == CNT_BIT_END) begin
                    w_cnt_nxt     = '0;
                    w_par_err_nxt = (even_parity(r_shift) != w_rx_s);
                    w_state_nxt   = STOP;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
`endif

            STOP: begin
                if (r_cnt == CNT_BIT_END) begin
                    w_cnt_nxt = '0;
                    if (w_rx_s) begin
`ifdef UART_DEBUG_RX_PARITY_EN
                        w_parity_err = r_par_err;
                        w_push       = !r_par_err;
`else
                        w_push       = 1'b1;
`endif
                        w_state_nxt  = IDLE;
                    end else begin
                        // Low stop bit: break or garbage; wait for the line to idle.
                        w_frame_err = 1'b1;
                        w_state_nxt = WAIT_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            WAIT_IDLE: begin
                if (w_rx_s) begin
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    uart_debug_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (w_push),
        .push_dat (r_shift),
        .pop      (bus.ready_i),
        .pop_dat  (bus.data_o),
        .full     (w_fifo_full),
        .empty    (w_fifo_empty),
        .count    (bus.count_o),
        .drop     (w_fifo_drop)
    );

    // Overflow stays set until reset so a consumer polling late still sees the loss.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_fifo_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign bus.valid_o     = !w_fifo_empty;
    assign bus.frame_err_o = r_frame_err;
    assign bus.overflow_o  = r_overflow;
`ifdef UART_DEBUG_RX_PARITY_EN
    assign bus.parity_err_o = r_parity_err;
`else
    assign bus.parity_err_o = 1'b0;
`endif

    // Full flag is implied by count_o at the interface; kept for the drop path inside the FIFO.
    logic w_unused;
    assign w_unused = w_fifo_full;

endmodule
